// File: rtl/ym_write_queue_if.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module  : ym_write_queue_if                                            |
// | Purpose : Bus bundle between the host pins, the write queue and jt51.  |
// |           Host side: cs_n, wr_n, a0, din (asynchronous to ymclk).      |
// |           Core side: ym_cs_n, ym_wr_n, ym_a0, ym_din (ymclk domain).   |
// |           ym_busy (jt51 dout[7]) exists only when                      |
// |           YM_WRITE_QUEUE_BUSY_POLL_EN is defined.                      |
// | Modports: master - host/environment side, slave - the write queue.     |
// | Revision: 1.0 - initial release                                        |
// +------------------------------------------------------------------------+
interface ym_write_queue_if;
  logic       cs_n;
  logic       wr_n;
  logic       a0;
  logic [7:0] din;
  logic       ym_cs_n;
  logic       ym_wr_n;
  logic       ym_a0;
  logic [7:0] ym_din;
`ifdef YM_WRITE_QUEUE_BUSY_POLL_EN
  logic       ym_busy;

  modport master (output cs_n, wr_n, a0, din, ym_busy,
                  input  ym_cs_n, ym_wr_n, ym_a0, ym_din);
  modport slave  (input  cs_n, wr_n, a0, din, ym_busy,
                  output ym_cs_n, ym_wr_n, ym_a0, ym_din);
`else
  modport master (output cs_n, wr_n, a0, din,
                  input  ym_cs_n, ym_wr_n, ym_a0, ym_din);
  modport slave  (input  cs_n, wr_n, a0, din,
                  output ym_cs_n, ym_wr_n, ym_a0, ym_din);
`endif
endinterface
`default_nettype wire

// File: rtl/ym_write_queue.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module  : ym_write_queue                                               |
// | Purpose : Captures asynchronous host writes, pairs register address    |
// |           with register data, buffers pairs in a FIFO and replays them |
// |           to jt51 as spaced cs_n/wr_n strobe sequences.                |
// | Ports   : clk      - ymclk, the only clock                             |
// |           rst_n    - synchronous active-low reset                      |
// |           bus      - host pins in, jt51 write port out (slave modport) |
// |           level    - FIFO occupancy                                    |
// |           overflow - sticky, a pair was dropped on a full FIFO         |
// |           busy     - FIFO non-empty or sequencer active                |
// | Option  : YM_WRITE_QUEUE_BUSY_POLL_EN - end the post-data gap by       |
// |           polling bus.ym_busy instead of counting DATA_GAP.            |
// | Revision: 1.0 - initial release                                        |
// +------------------------------------------------------------------------+
module ym_write_queue #(
  parameter int DEPTH      = 16,
  parameter int STROBE_LEN = 2,
  parameter int ADDR_GAP   = 4,
  parameter int DATA_GAP   = 68
) (
  input  logic                   clk,
  input  logic                   rst_n,
  ym_write_queue_if.slave        bus,
  output logic [$clog2(DEPTH):0] level,
  output logic                   overflow,
  output logic                   busy
);

  localparam int AW      = $clog2(DEPTH);
  localparam int LW      = AW + 1;
  localparam int MAX_A   = (STROBE_LEN > ADDR_GAP) ? STROBE_LEN : ADDR_GAP;
  localparam int MAX_B   = (MAX_A > DATA_GAP) ? MAX_A : DATA_GAP;
  localparam int MAX_ALL = (MAX_B > 4) ? MAX_B : 4;
  localparam int CW      = $clog2(MAX_ALL);

  localparam logic [CW-1:0] C_STB_TC = CW'(STROBE_LEN - 1);
  localparam logic [CW-1:0] C_AG_TC  = CW'(ADDR_GAP - 1);
`ifdef YM_WRITE_QUEUE_BUSY_POLL_EN
  localparam logic [CW-1:0] C_POLL_TC = CW'(3);
`else
  localparam logic [CW-1:0] C_DG_TC  = CW'(DATA_GAP - 1);
`endif

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_ADDR  = 3'd1;
  localparam logic [2:0] ST_GAP_A = 3'd2;
  localparam logic [2:0] ST_DATA  = 3'd3;
  localparam logic [2:0] ST_GAP_D = 3'd4;

  // ---------------- input capture ----------------
  logic       w_write_n;
  logic       s1_wn_q, s2_wn_q, s3_wn_q;
  logic       s1_a0_q, s2_a0_q, cap_a0_q;
  logic [7:0] s1_din_q, s2_din_q, cap_din_q;
  logic       rise_q;

  assign w_write_n = bus.cs_n | bus.wr_n;

  // write_n flops reset high so leaving reset never looks like a rise.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_wn_q   <= 1'b1;
      s2_wn_q   <= 1'b1;
      s3_wn_q   <= 1'b1;
      s1_a0_q   <= 1'b0;
      s2_a0_q   <= 1'b0;
      cap_a0_q  <= 1'b0;
      s1_din_q  <= '0;
      s2_din_q  <= '0;
      cap_din_q <= '0;
      rise_q    <= 1'b0;
    end else begin
      s1_wn_q  <= w_write_n;
      s2_wn_q  <= s1_wn_q;
      s3_wn_q  <= s2_wn_q;
      s1_a0_q  <= bus.a0;
      s2_a0_q  <= s1_a0_q;
      s1_din_q <= bus.din;
      s2_din_q <= s1_din_q;
      // Freeze a0/din at the last cycle the synchronised strobe was low.
      if (!s2_wn_q) begin
        cap_a0_q  <= s2_a0_q;
        cap_din_q <= s2_din_q;
      end
      // Registered rise gives the push one extra cycle of settling.
      rise_q <= s2_wn_q & ~s3_wn_q;
    end
  end

  // ---------------- pairing + FIFO ----------------
  logic [7:0]    pend_addr_q;
  logic [15:0]   mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [LW-1:0] level_q;
  logic          overflow_q;
  logic          w_push, w_full, w_push_ok, w_pop;
  logic [15:0]   w_head;

  assign w_push    = rise_q & cap_a0_q;
  assign w_full    = (level_q == LW'(DEPTH));   // pre-pop level on purpose
  assign w_push_ok = w_push & ~w_full;
  assign w_head    = mem_q[rd_ptr_q];

  always_ff @(posedge clk) begin
    if (w_push_ok) mem_q[wr_ptr_q] <= {pend_addr_q, cap_din_q};
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pend_addr_q <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      level_q     <= '0;
      overflow_q  <= 1'b0;
    end else begin
      if (rise_q && !cap_a0_q) pend_addr_q <= cap_din_q;
      if (w_push_ok) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (w_pop)     rd_ptr_q <= rd_ptr_q + AW'(1);
      level_q <= level_q + LW'(w_push_ok) - LW'(w_pop);
      if (w_push && w_full) overflow_q <= 1'b1;
    end
  end

  // ---------------- replay sequencer ----------------
  logic [2:0]    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d, w_tc;
  logic [7:0]    issue_val_q;
  logic          ym_cs_n_q, ym_cs_n_d;
  logic          ym_a0_q, ym_a0_d;
  logic [7:0]    ym_din_q, ym_din_d;
`ifdef YM_WRITE_QUEUE_BUSY_POLL_EN
  logic          busy_lo_q;   // ym_busy was low on the previous GAP_D cycle
`endif

  // State register (plus the registered outputs derived from next state).
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      issue_val_q <= '0;
      ym_cs_n_q   <= 1'b1;
      ym_a0_q     <= 1'b0;
      ym_din_q    <= '0;
`ifdef YM_WRITE_QUEUE_BUSY_POLL_EN
      busy_lo_q   <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      ym_cs_n_q <= ym_cs_n_d;
      ym_a0_q   <= ym_a0_d;
      ym_din_q  <= ym_din_d;
      if (w_pop) issue_val_q <= w_head[7:0];
`ifdef YM_WRITE_QUEUE_BUSY_POLL_EN
      busy_lo_q <= (state_q == ST_GAP_D) & ~bus.ym_busy;
`endif
    end
  end

  // Next state; the counter saturates at the current state's terminal count.
  always_comb begin
    state_d = state_q;
    w_pop   = 1'b0;
    w_tc    = C_STB_TC;
    unique case (state_q)
      ST_IDLE: begin
        if (level_q != '0) begin
          w_pop   = 1'b1;
          state_d = ST_ADDR;
        end
      end
      ST_ADDR: begin
        w_tc = C_STB_TC;
        if (cnt_q == w_tc) state_d = ST_GAP_A;
      end
      ST_GAP_A: begin
        w_tc = C_AG_TC;
        if (cnt_q == w_tc) state_d = ST_DATA;
      end
      ST_DATA: begin
        w_tc = C_STB_TC;
        if (cnt_q == w_tc) state_d = ST_GAP_D;
      end
      ST_GAP_D: begin
`ifdef YM_WRITE_QUEUE_BUSY_POLL_EN
        // Four-cycle minimum, then two consecutive low samples of ym_busy.
        w_tc = C_POLL_TC;
        if (cnt_q == w_tc && busy_lo_q && !bus.ym_busy) state_d = ST_IDLE;
`else
        w_tc = C_DG_TC;
        if (cnt_q == w_tc) state_d = ST_IDLE;
`endif
      end
      default: state_d = ST_IDLE;
    endcase
    if (state_d != state_q)  cnt_d = '0;
    else if (cnt_q == w_tc)  cnt_d = cnt_q;
    else                     cnt_d = cnt_q + CW'(1);
  end

  // Outputs are computed from the next state so they change on entry.
  always_comb begin
    ym_cs_n_d = ~((state_d == ST_ADDR) || (state_d == ST_DATA));
    ym_a0_d   = ym_a0_q;
    ym_din_d  = ym_din_q;
    if (state_q == ST_IDLE && state_d == ST_ADDR) begin
      ym_a0_d  = 1'b0;
      ym_din_d = w_head[15:8];
    end else if (state_q == ST_GAP_A && state_d == ST_DATA) begin
      ym_a0_d  = 1'b1;
      ym_din_d = issue_val_q;
    end
  end

  assign bus.ym_cs_n = ym_cs_n_q;
  assign bus.ym_wr_n = ym_cs_n_q;
  assign bus.ym_a0   = ym_a0_q;
  assign bus.ym_din  = ym_din_q;
  assign level       = level_q;
  assign overflow    = overflow_q;
  assign busy        = (level_q != '0) || (state_q != ST_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_ym_write_queue.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module  : tb_ym_write_queue                                            |
// | Purpose : Self-checking bench for ym_write_queue. Expected strobes are |
// |           queued when host writes are issued; a negedge monitor pops   |
// |           and compares each jt51 strobe as it appears.                 |
// | Revision: 1.0 - initial release                                        |
// +------------------------------------------------------------------------+
module tb_ym_write_queue;
  logic       clk = 1'b0;
  logic       rst_n;
  logic [4:0] level;
  logic       overflow;
  logic       busy;

  ym_write_queue_if bus_if ();

  ym_write_queue dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .bus      (bus_if.slave),
    .level    (level),
    .overflow (overflow),
    .busy     (busy)
  );

  always #5 clk = ~clk;

`ifdef YM_WRITE_QUEUE_BUSY_POLL_EN
  initial bus_if.ym_busy = 1'b0;
`endif

  int         pass_cnt  = 0;
  int         total_cnt = 0;
  logic [8:0] sb[$];          // {a0, din} expected per strobe
  logic [7:0] pend = 8'h00;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  // ---------------- monitor ----------------
  logic       m_prev = 1'b1;
  logic       m_last_a0 = 1'b1;
  int         m_low = 0;
  int         m_high = 0;
  logic [8:0] m_exp;

  always @(negedge clk) begin
    if (!rst_n) begin
      m_prev    = 1'b1;
      m_last_a0 = 1'b1;
      m_low     = 0;
      m_high    = 0;
    end else begin
      if (bus_if.ym_cs_n == 1'b0) begin
        if (m_prev) begin
          check("wr_n_eq_cs_n", bus_if.ym_wr_n, bus_if.ym_cs_n);
          if (sb.size() == 0) begin
            check("unexpected_strobe", {bus_if.ym_a0, bus_if.ym_din}, 9'h000);
          end else begin
            m_exp = sb.pop_front();
            check("strobe_a0_din", {bus_if.ym_a0, bus_if.ym_din}, m_exp);
          end
          if (bus_if.ym_a0 && !m_last_a0) check("addr_gap", m_high, 4);
          m_last_a0 = bus_if.ym_a0;
          m_low = 0;
        end
        m_low++;
      end else begin
        if (!m_prev) begin
          check("strobe_len", m_low, 2);
          m_high = 0;
        end
        m_high++;
      end
      m_prev = bus_if.ym_cs_n;
    end
  end

  // ---------------- stimulus ----------------
  task automatic host_write(input logic a, input logic [7:0] d, input bit push_exp);
    bus_if.a0   = a;
    bus_if.din  = d;
    bus_if.cs_n = 1'b0;
    bus_if.wr_n = 1'b0;
    repeat (4) @(negedge clk);
    bus_if.wr_n = 1'b1;
    bus_if.cs_n = 1'b1;
    if (!a) pend = d;
    else if (push_exp) begin
      sb.push_back({1'b0, pend});
      sb.push_back({1'b1, d});
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic wait_idle(input int budget, output int peak);
    int n;
    peak = 0;
    n = 0;
    repeat (4) begin
      @(negedge clk);
      if (int'(level) > peak) peak = int'(level);
    end
    while ((busy || sb.size() != 0) && n < budget) begin
      @(negedge clk);
      if (int'(level) > peak) peak = int'(level);
      n++;
    end
    check("drain_in_budget", (n < budget), 1);
  endtask

  initial begin
    int  pk;
    int  n;
    bit  seen;
    rst_n       = 1'b0;
    bus_if.cs_n = 1'b1;
    bus_if.wr_n = 1'b1;
    bus_if.a0   = 1'b0;
    bus_if.din  = 8'h00;
    repeat (3) @(negedge clk);
    // Reset state
    check("rst_ym_cs_n",  bus_if.ym_cs_n, 1);
    check("rst_ym_wr_n",  bus_if.ym_wr_n, 1);
    check("rst_ym_a0",    bus_if.ym_a0, 0);
    check("rst_ym_din",   bus_if.ym_din, 0);
    check("rst_level",    level, 0);
    check("rst_overflow", overflow, 0);
    check("rst_busy",     busy, 0);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    check("post_rst_busy", busy, 0);

    // Single pair with latency checks on the data write
    host_write(1'b0, 8'h20, 1'b0);
    bus_if.a0   = 1'b1;
    bus_if.din  = 8'hC7;
    bus_if.cs_n = 1'b0;
    bus_if.wr_n = 1'b0;
    repeat (4) @(negedge clk);
    bus_if.wr_n = 1'b1;
    bus_if.cs_n = 1'b1;
    sb.push_back({1'b0, 8'h20});
    sb.push_back({1'b1, 8'hC7});
    @(posedge clk);                    // edge N: s1 sees the rise
    repeat (2) @(posedge clk);
    #1 check("lat_n2_level", level, 0);
    @(posedge clk);
    #1 check("lat_n3_level", level, 1);
    check("lat_n3_cs_n", bus_if.ym_cs_n, 1);
    @(posedge clk);
    #1 check("lat_n4_cs_n", bus_if.ym_cs_n, 0);
    check("lat_n4_busy", busy, 1);
    n = 0;
    while (!(bus_if.ym_cs_n == 1'b0 && bus_if.ym_a0 == 1'b1) && n < 100) begin
      @(negedge clk);
      n++;
    end
    while (bus_if.ym_cs_n == 1'b0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("single_data_seen", (n < 200), 1);
    n = 0;
    while (busy && n < 200) begin
      n++;
      @(negedge clk);
    end
`ifndef YM_WRITE_QUEUE_BUSY_POLL_EN
    check("busy_fall_after_data", n, 68);
`endif
    wait_idle(500, pk);

    // Repeated data to one register
    host_write(1'b0, 8'h08, 1'b0);
    host_write(1'b1, 8'h01, 1'b1);
    host_write(1'b1, 8'h02, 1'b1);
    host_write(1'b1, 8'h03, 1'b1);
    wait_idle(1000, pk);
    check("rep_peak_le3", (pk <= 3), 1);
    check("rep_peak_nonzero", (pk > 0), 1);
    check("rep_overflow", overflow, 0);

    // Overflow: 20 data writes at one per 6 cycles against a 77-cycle drain.
    // Two pops land inside the burst, so writes 1..18 fit and 19, 20 drop.
    host_write(1'b0, 8'h30, 1'b0);
    for (int i = 0; i < 20; i++) host_write(1'b1, 8'h40 + 8'(i), (i < 18));
    check("ovf_flag_burst", overflow, 1);
    wait_idle(3000, pk);
    check("ovf_peak", pk, 16);
    check("ovf_flag_sticky", overflow, 1);
    check("ovf_level_drained", level, 0);

    // Reset during a DATA strobe
    host_write(1'b0, 8'h11, 1'b0);
    host_write(1'b1, 8'h22, 1'b1);
    host_write(1'b1, 8'h33, 1'b1);
    n = 0;
    while (!(bus_if.ym_cs_n == 1'b0 && bus_if.ym_a0 == 1'b1) && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("rst_data_seen", (n < 200), 1);
    @(posedge clk);
    #2 rst_n = 1'b0;
    @(posedge clk);
    #1 check("midrst_cs_n", bus_if.ym_cs_n, 1);
    check("midrst_wr_n", bus_if.ym_wr_n, 1);
    check("midrst_level", level, 0);
    check("midrst_busy", busy, 0);
    check("midrst_overflow", overflow, 0);
    sb.delete();
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    seen = 1'b0;
    repeat (200) begin
      @(negedge clk);
      if (bus_if.ym_cs_n == 1'b0) seen = 1'b1;
    end
    check("midrst_no_strobe", seen, 0);
    check("midrst_busy_after", busy, 0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
`default_nettype wire
